// File: rtl/jk_pkg.sv
// jk_pkg: JK cell op encodings and the per-bit J/K drive function for the modulo counter.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // {J,K} that moves a cell from q to nxt; only ever yields hold, set or clear.
    function automatic logic [1:0] jk_drive(input logic q, input logic nxt);
        return {nxt & ~q, ~nxt & q};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: single falling-edge JK flip-flop with async active-low reset to rst_val.
// Ports: clk (falling edge), rst_n (async, active low), rst_val (reset value),
//        j/k (JK inputs), q (state), qbar (combinational ~q).
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else begin
            case ({j, k})
                JK_HOLD: q <= q;
                JK_CLR:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS up/down counter built from a bank of JK cells.
// Ports: clk (all state updates on falling edge), rst_n (async, active low),
//        en (count enable), dir (1 up, 0 down), load/load_val (sync clamped load, beats en),
//        count (current value), count_bar (~count), tc (registered one-cycle wrap pulse).
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) ||
        RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
        $fatal(1, "jk_mod_counter: illegal MODULUS/RESET_VAL for WIDTH");
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ld;
    logic             wrap;

    // Wrap is detected by comparing against the modulus ends, never by overflow;
    // the extra compare bit lets MODULUS == 2**WIDTH be represented.
    always_comb begin
        ld   = ({1'b0, load_val} < (WIDTH + 1)'(MODULUS)) ? load_val : MAX;
        wrap = !load && en && (dir ? (q == MAX) : (q == '0));
        nxt  = load ? ld :
               !en  ? q  :
               wrap ? (dir ? '0 : MAX) :
               dir  ? q + WIDTH'(1) : q - WIDTH'(1);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic [1:0] jk;
        assign jk = jk_drive(q[i], nxt[i]);
        jk_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .rst_val (RST[i]),
            .j       (jk[1]),
            .k       (jk[0]),
            .q       (q[i]),
            .qbar    (qb[i])
        );
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) tc <= 1'b0;
        else        tc <= wrap;
    end

    assign count     = q;
    assign count_bar = qb;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed scoreboard bench for jk_mod_counter (MOD-10 and MOD-2 instances).
module tb_jk_mod_counter;

    typedef struct {
        logic [3:0] c;
        logic       t;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t sb2[$];
    int checks = 0;
    int errors = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0, dir = 1'b1, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] count, count_bar;
    logic       tc;
    logic       en2 = 1'b0, dir2 = 1'b1;
    logic [0:0] c2, cb2;
    logic       tc2;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .count(count), .count_bar(count_bar), .tc(tc)
    );

    jk_mod_counter #(.WIDTH(1), .MODULUS(2), .RESET_VAL(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .dir(dir2), .load(1'b0), .load_val(1'b0),
        .count(c2), .count_bar(cb2), .tc(tc2)
    );

    task automatic chk();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard empty");
        end else begin
            x = sb.pop_front();
            checks++;
            assert (count === x.c) else begin
                errors++;
                $error("FAIL %s count got %0d expected %0d", x.tag, count, x.c);
            end
            checks++;
            assert (count_bar === ~x.c) else begin
                errors++;
                $error("FAIL %s count_bar got %h expected %h", x.tag, count_bar, ~x.c);
            end
            checks++;
            assert (tc === x.t) else begin
                errors++;
                $error("FAIL %s tc got %b expected %b", x.tag, tc, x.t);
            end
        end
    endtask

    task automatic chk2();
        exp_t x;
        if (sb2.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard2 empty");
        end else begin
            x = sb2.pop_front();
            checks++;
            assert (c2 === x.c[0:0] && cb2 === ~x.c[0:0]) else begin
                errors++;
                $error("FAIL %s count got %b/%b expected %b", x.tag, c2, cb2, x.c[0]);
            end
            checks++;
            assert (tc2 === x.t) else begin
                errors++;
                $error("FAIL %s tc got %b expected %b", x.tag, tc2, x.t);
            end
        end
    endtask

    // Drive inputs half a cycle before the active falling edge, compare on the rising edge after it.
    task automatic step(input logic l, input logic e, input logic d, input logic [3:0] lv,
                        input logic [3:0] ec, input logic et, input string tag);
        load = l; en = e; dir = d; load_val = lv;
        sb.push_back('{ec, et, tag});
        @(negedge clk);
        @(posedge clk);
        #1;
        chk();
    endtask

    task automatic step2(input logic e, input logic d, input logic ec, input logic et,
                         input string tag);
        en2 = e; dir2 = d;
        sb2.push_back('{{3'b000, ec}, et, tag});
        @(negedge clk);
        @(posedge clk);
        #1;
        chk2();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        sb.push_back('{4'd3, 1'b0, "reset"});
        chk();
        sb2.push_back('{4'd0, 1'b0, "reset2"});
        chk2();
        @(posedge clk);
        rst_n = 1'b1;
        #1;
        step(1, 0, 1, 4'd8, 4'd8, 0, "load8");
        step(0, 1, 1, 4'd0, 4'd9, 0, "up9");
        step(0, 1, 1, 4'd0, 4'd0, 1, "upwrap");
        step(0, 1, 1, 4'd0, 4'd1, 0, "up1");
        step(0, 1, 0, 4'd0, 4'd0, 0, "dn0");
        step(0, 1, 0, 4'd0, 4'd9, 1, "dnwrap");
        step(0, 1, 0, 4'd0, 4'd8, 0, "dn8");
        step(0, 0, 0, 4'd0, 4'd8, 0, "hold");
        step(1, 1, 1, 4'd6, 4'd6, 0, "load6");
        step(1, 1, 0, 4'd13, 4'd9, 0, "clamp13");
        step(1, 0, 1, 4'd10, 4'd9, 0, "clamp10");
        step(1, 1, 1, 4'd2, 4'd2, 0, "loadatmax");
        step(1, 1, 0, 4'd7, 4'd7, 0, "load7");
        rst_n = 1'b0;
        #1;
        sb.push_back('{4'd3, 1'b0, "midreset"});
        chk();
        rst_n = 1'b1;
        step(0, 1, 1, 4'd0, 4'd4, 0, "resume4");
        step(0, 1, 1, 4'd0, 4'd5, 0, "resume5");
        step2(1, 1, 1'b1, 0, "m2up1");
        step2(1, 1, 1'b0, 1, "m2wrapa");
        step2(1, 0, 1'b1, 1, "m2wrapb");
        step2(1, 1, 1'b0, 1, "m2wrapc");
        step2(1, 0, 1'b1, 1, "m2wrapd");
        step2(1, 1, 1'b0, 1, "m2upwrap");
        step2(1, 1, 1'b1, 0, "m2up");
        step2(0, 1, 1'b1, 0, "m2hold");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
